// File: rtl/player_missile.sv
// player_missile: player laser shot launch, upward flight, explosion timing and re-arm.
// Optional FIRE_BUFFER_EN keeps one fire press made during flight/explosion for the next launch.
module player_missile #(
  parameter int PLAYER_Y    = 440,
  parameter int MUZZLE_OFF  = 14,
  parameter int PROJ_H      = 16,
  parameter int STEP        = 8,
  parameter int TOP_Y       = 32,
  parameter int PARK_Y      = 480,
  parameter int EXPL_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       frame,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic       hit_invader,
  input  logic       hit_missile,
  output logic [9:0] pm_x,
  output logic [9:0] pm_y,
  output logic       active,
  output logic       exploding,
  output logic [7:0] shot_count
);
  typedef enum logic [1:0] {IDLE, FLY, EXPLODE} state_t;
  localparam logic [9:0] LAUNCH_Y  = 10'(PLAYER_Y - PROJ_H);
  localparam logic [9:0] TOP_LIMIT = 10'(TOP_Y + STEP);
  localparam logic [9:0] PARK      = 10'(PARK_Y);
  localparam logic [7:0] EXPL_LAST = 8'(EXPL_FRAMES - 1);
  state_t state, state_nx;
  logic [9:0] x_nx, y_nx;
  logic [7:0] cnt_nx, expl_cnt, expl_nx;
  logic fire_d, fire_req, req_nx, rise;
  assign rise = fire & ~fire_d;
  always_comb begin
    state_nx = state;
    x_nx     = pm_x;
    y_nx     = pm_y;
    cnt_nx   = shot_count;
    req_nx   = fire_req;
    expl_nx  = expl_cnt;
    case (state)
      IDLE: begin
        if (rise) req_nx = 1'b1;
        if (frame && fire_req) begin
          x_nx     = player_x + 10'(MUZZLE_OFF);
          y_nx     = LAUNCH_Y;
          cnt_nx   = shot_count + 8'd1;
          req_nx   = 1'b0;
          state_nx = FLY;
        end
      end
      FLY: begin
`ifdef FIRE_BUFFER_EN
        if (rise) req_nx = 1'b1;
`endif
        // a hit freezes the shot even when a frame arrives in the same cycle
        if (hit_invader || hit_missile) begin
          state_nx = EXPLODE;
          expl_nx  = '0;
        end else if (frame) begin
          if (pm_y < TOP_LIMIT) begin
            y_nx     = 10'(TOP_Y);
            state_nx = EXPLODE;
            expl_nx  = '0;
          end else y_nx = pm_y - 10'(STEP);
        end
      end
      EXPLODE: begin
`ifdef FIRE_BUFFER_EN
        if (rise) req_nx = 1'b1;
`endif
        if (frame) begin
          expl_nx = expl_cnt + 8'd1;
          if (expl_cnt == EXPL_LAST) begin
            state_nx = IDLE;
            y_nx     = PARK;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pm_x       <= '0;
      pm_y       <= PARK;
      active     <= 1'b0;
      exploding  <= 1'b0;
      shot_count <= '0;
      fire_req   <= 1'b0;
      fire_d     <= 1'b0;
      expl_cnt   <= '0;
    end else if (restart) begin
      state      <= IDLE;
      pm_x       <= '0;
      pm_y       <= PARK;
      active     <= 1'b0;
      exploding  <= 1'b0;
      shot_count <= '0;
      fire_req   <= 1'b0;
      fire_d     <= 1'b0;
      expl_cnt   <= '0;
    end else begin
      state      <= state_nx;
      pm_x       <= x_nx;
      pm_y       <= y_nx;
      active     <= state_nx == FLY;
      exploding  <= state_nx == EXPLODE;
      shot_count <= cnt_nx;
      fire_req   <= req_nx;
      fire_d     <= fire;
      expl_cnt   <= expl_nx;
    end
  end
endmodule

// File: tb/tb_player_missile.sv
// tb_player_missile: directed and random stimulus against a frame-level reference model.
module tb_player_missile;
  logic clk = 0, rst_n = 0, restart = 0, frame = 0, fire = 0;
  logic hit_invader = 0, hit_missile = 0;
  logic [9:0] player_x = 0;
  logic [9:0] pm_x, pm_y;
  logic active, exploding;
  logic [7:0] shot_count;
  int checks = 0, errors = 0;
  int m_x, m_y, m_cnt, m_left;
  bit m_fly, m_exp, m_req, m_fd;

  player_missile dut (.clk(clk), .rst_n(rst_n), .restart(restart), .frame(frame), .fire(fire),
    .player_x(player_x), .hit_invader(hit_invader), .hit_missile(hit_missile), .pm_x(pm_x),
    .pm_y(pm_y), .active(active), .exploding(exploding), .shot_count(shot_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 480; m_cnt = 0; m_left = 0;
    m_fly = 0; m_exp = 0; m_req = 0; m_fd = 0;
  endtask

  // one clock of game rules, using the inputs currently applied
  task automatic model_step();
    bit edge_seen;
    edge_seen = fire && !m_fd;
    if (restart) begin
      model_reset();
      return;
    end
    if (!m_fly && !m_exp) begin
      if (frame && m_req) begin
        m_x = (int'(player_x) + 14) % 1024;
        m_y = 440 - 16;
        m_cnt = (m_cnt + 1) % 256;
        m_req = 0;
        m_fly = 1;
      end else if (edge_seen) m_req = 1;
    end else begin
`ifdef FIRE_BUFFER_EN
      if (edge_seen) m_req = 1;
`endif
      if (m_fly) begin
        if (hit_invader || hit_missile) begin
          m_fly = 0; m_exp = 1; m_left = 8;
        end else if (frame) begin
          if (m_y - 8 < 32) begin
            m_y = 32; m_fly = 0; m_exp = 1; m_left = 8;
          end else m_y = m_y - 8;
        end
      end else if (frame) begin
        m_left--;
        if (m_left == 0) begin
          m_exp = 0; m_y = 480;
        end
      end
    end
    m_fd = fire;
  endtask

  task automatic check_all();
    chk("pm_x", pm_x, m_x);
    chk("pm_y", pm_y, m_y);
    chk("active", active, m_fly);
    chk("exploding", exploding, m_exp);
    chk("shot_count", shot_count, m_cnt);
  endtask

  task automatic cycle(input bit f);
    frame = f;
    model_step();
    @(posedge clk);
    #1;
    check_all();
    frame = 0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      cycle(0);
      cycle(1);
    end
  endtask

  task automatic launch();
    fire = 1; cycle(0);
    fire = 0; cycle(1);
  endtask

  task automatic end_shot();
    hit_invader = 1; cycle(0);
    hit_invader = 0; frames(8);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    check_all();
    rst_n = 1;
    cycle(0);
    // launch from x=100
    player_x = 100;
    launch();
    chk("launch_x", pm_x, 114);
    chk("launch_y", pm_y, 424);
    chk("launch_cnt", shot_count, 1);
    cycle(1);
    chk("first_step", pm_y, 416);
    // free flight to the top
    frames(48);
    chk("at_top", pm_y, 32);
    chk("at_top_active", active, 1);
    cycle(1);
    chk("top_y", pm_y, 32);
    chk("top_expl", exploding, 1);
    frames(7);
    chk("expl_hold", exploding, 1);
    frames(1);
    chk("rearm_y", pm_y, 480);
    chk("rearm_expl", exploding, 0);
    // hit has priority over a same-cycle frame
    launch();
    frames(28);
    chk("pre_hit_y", pm_y, 200);
    hit_invader = 1; cycle(1); hit_invader = 0;
    chk("hit_y", pm_y, 200);
    chk("hit_active", active, 0);
    chk("hit_expl", exploding, 1);
    frames(8);
    // held fire does not auto-repeat
    fire = 1; cycle(0); cycle(1);
    chk("held_launch", active, 1);
    hit_missile = 1; cycle(0); hit_missile = 0;
    frames(8);
    frames(3);
    chk("held_no_repeat", active, 0);
    fire = 0; cycle(0);
    fire = 1; cycle(0); cycle(1);
    chk("repress_launch", active, 1);
    // press during flight
    fire = 0; cycle(0);
    fire = 1; cycle(0);
    fire = 0;
    end_shot();
    frames(1);
`ifdef FIRE_BUFFER_EN
    chk("buffered_launch", active, 1);
`else
    chk("unbuffered_none", active, 0);
`endif
    end_shot();
    // async reset mid-flight
    launch();
    frames(2);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    chk("rst_y", pm_y, 480);
    chk("rst_cnt", shot_count, 0);
    rst_n = 1;
    cycle(0);
    // restart mid-flight
    launch();
    frames(1);
    restart = 1; cycle(0); restart = 0;
    chk("restart_active", active, 0);
    // shot_count wraps after 256 launches
    repeat (256) begin
      launch();
      end_shot();
    end
    chk("wrap_cnt", shot_count, 0);
    // random play
    repeat (4000) begin
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      if ($urandom_range(0, 31) == 0) player_x = 10'($urandom_range(0, 1023));
      hit_invader = $urandom_range(0, 23) == 0;
      hit_missile = $urandom_range(0, 23) == 0;
      restart = $urandom_range(0, 299) == 0;
      cycle($urandom_range(0, 3) == 0);
    end
    restart = 0; hit_invader = 0; hit_missile = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/player_missile.md
Name: player_missile

Overview:
- Controls the player's single laser shot, the upward counterpart of the invader missile generator.
- Captures fire button presses and launches one shot from the player cannon on a frame tick.
- Moves the shot upward once per frame and ends it on an invader hit, an invader-missile hit or the top of the playfield.
- Shows a timed explosion, then re-arms. Feeds position and active flags to the renderer and collision logic.

Parameters:
- PLAYER_Y, 440, top row of the player cannon sprite
- MUZZLE_OFF, 14, x offset from player_x to the shot's left column
- PROJ_H, 16, scaled projectile height
- STEP, 8, pixels moved per frame
- TOP_Y, 32, highest row the shot may occupy
- PARK_Y, 480, off-screen y while idle (RES_V)
- EXPL_FRAMES, 8, explosion duration in frames

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- restart  in  1  synchronous game restart, active-high, same effect as reset
- frame  in  1  one-cycle pulse per video frame
- fire  in  1  fire button level (already debounced)
- player_x  in  10  player cannon left x
- hit_invader  in  1  shot overlaps a live invader (level)
- hit_missile  in  1  shot overlaps an invader missile (level)
- pm_x  out  10  shot x
- pm_y  out  10  shot y
- active  out  1  shot in flight, collidable
- exploding  out  1  explosion sprite shown at pm_x/pm_y
- shot_count  out  8  launches since reset, wraps 255->0

Behaviour:
- Reset (rst_n low, async) or restart (sync, highest priority) sets: state IDLE, pm_x=0, pm_y=PARK_Y, active=0, exploding=0, shot_count=0, fire_req=0, fire_d=0, expl_cnt=0. Applies mid-flight or mid-explosion.
- fire_d is fire registered each clk. A rising edge (fire & ~fire_d) is counted only in IDLE and sets fire_req. Holding fire does not auto-repeat.
- IDLE: active=0, exploding=0, pm_y=PARK_Y. On frame with fire_req=1:
  - pm_x<=player_x+MUZZLE_OFF, pm_y<=PLAYER_Y-PROJ_H.
  - shot_count++, fire_req<=0, go to FLY.
  - An edge in the same cycle as a frame sets fire_req and launches on the next frame.
- FLY: active=1.
  - If hit_invader or hit_missile is high, go to EXPLODE next cycle. Position is frozen. This has priority over a frame in the same cycle (no move).
  - Else on frame: if pm_y < TOP_Y+STEP, set pm_y<=TOP_Y and go to EXPLODE. Otherwise pm_y<=pm_y-STEP. The compare comes before the subtract, so there is never 10-bit underflow.
  - Rising edges of fire are dropped.
- EXPLODE: active=0, exploding=1, position held, expl_cnt cleared on entry.
  - Each frame expl_cnt++.
  - On the frame where expl_cnt==EXPL_FRAMES-1, go to IDLE, pm_y<=PARK_Y, exploding<=0.
  - Hit inputs are ignored here.
- All outputs are registered. State changes take effect on the clk after the triggering condition.
- pm_x does not track player_x after launch.

Optional Feature:
- Macro FIRE_BUFFER_EN.
- Defined: one rising edge of fire during FLY or EXPLODE sets fire_req. The buffer holds one press; further presses are ignored. The first frame in IDLE then launches immediately.
- Undefined: edges outside IDLE are discarded, so the player must press again after returning to IDLE.

Test Plan:
- Reset mid-flight: launch, then pulse rst_n low between frames -> active=0, pm_y=480, shot_count=0 immediately (async).
- Fire press with player_x=100, then one frame -> FLY, pm_x=114, pm_y=424, shot_count=1. Next frame -> pm_y=416.
- Free flight to top: after launch, 49 frames bring pm_y to 32; frame 50 -> EXPLODE, pm_y=32, exploding=1. Frame 58 -> IDLE, pm_y=480.
- Hit priority: hit_invader=1 in the same cycle as frame at pm_y=200 -> EXPLODE, pm_y stays 200, active=0 next clk.
- Fire held high across launch and return to IDLE -> no second launch. Release and re-press -> launch on the next frame.
- Press during FLY: without FIRE_BUFFER_EN, no launch after the explosion ends. With it, launch on the first IDLE frame and shot_count +1; 256 launches wrap shot_count to 0.
